cacheline_burst_adapter: RTL and testbench

Converts one 256-bit cacheline transfer from the data cache into a 4-beat, 64-bit burst on the physical-memory/arbiter port. It sits directly below the data cache, which is fed by the 32-bit-to-256-bit CPU bus adapter. Reads assemble four beats into one line. Writes split one line into four beats. The cache sees a single request/response handshake.

---
 rtl/cache_types_pkg.sv | 25 ++
 rtl/cacheline_burst_adapter_if.sv | 29 ++
 rtl/burst_beat_counter.sv | 31 +++
 rtl/cacheline_burst_adapter.sv | 101 ++++++++++
 tb/tb_cacheline_burst_adapter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_types_pkg.sv
// Shared cacheline/burst types and constants for the cache-to-memory burst path.
// Beat 0 of a line is its least-significant BEAT_W bits.
package cache_types_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned BEATS       = LINE_W / BEAT_W;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W       = $clog2(BEATS);

  typedef logic [LINE_W-1:0]             cacheline_t;
  typedef logic [BEAT_W-1:0]             beat_t;
  typedef logic [ADDR_W-1:0]             addr_t;
  typedef logic [CNT_W-1:0]              beat_idx_t;
  // Same bits as cacheline_t, viewed as an array of beats.
  typedef logic [BEATS-1:0][BEAT_W-1:0]  line_beats_t;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} burst_state_t;

  function automatic addr_t line_align(addr_t addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_burst_adapter_if.sv
// Cache-side line handshake plus memory-side burst port of the burst adapter.
// The slave modport is the adapter's view; master is the cache/memory side.
interface cacheline_burst_adapter_if;
  import cache_types_pkg::*;

  cacheline_t line_i;
  cacheline_t line_o;
  addr_t      address_i;
  logic       read_i;
  logic       write_i;
  logic       resp_o;
  beat_t      burst_i;
  beat_t      burst_o;
  addr_t      address_o;
  logic       read_o;
  logic       write_o;
  logic       resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/burst_beat_counter.sv
// Beat index within a burst; last_o flags the strobe that completes the line.
module burst_beat_counter
  import cache_types_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en_i,
  input  logic      clr_i,
  output beat_idx_t cnt_o,
  output logic      last_o
);

  localparam beat_idx_t LastIdx = beat_idx_t'(BEATS - 1);

  beat_idx_t cnt_q;

  // Natural wrap from LastIdx back to 0 happens only on the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + beat_idx_t'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = en_i && (cnt_q == LastIdx);

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Turns one cacheline read/write from the data cache into a 4-beat memory burst.
// All outputs are registered; write requests win over reads when both are pending.
module cacheline_burst_adapter
  import cache_types_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  cacheline_burst_adapter_if.slave        bus_io
);

  burst_state_t state_q;
  line_beats_t  line_q;
  line_beats_t  wbuf_q;
  beat_t        burst_q;
  addr_t        addr_q;
  logic         read_q;
  logic         write_q;
  logic         resp_q;

  beat_idx_t    cnt;
  logic         last_beat;
  logic         beat_en;

  // resp_i only counts as a beat while a burst is actually in flight.
  assign beat_en = bus_io.resp_i && ((state_q == RD) || (state_q == WR));

  burst_beat_counter u_beat_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (beat_en),
    .clr_i  (state_q == IDLE),
    .cnt_o  (cnt),
    .last_o (last_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      line_q  <= '0;
      wbuf_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus_io.write_i) begin
            wbuf_q  <= bus_io.line_i;
            burst_q <= bus_io.line_i[BEAT_W-1:0];
            addr_q  <= line_align(bus_io.address_i);
            write_q <= 1'b1;
            state_q <= WR;
          end else if (bus_io.read_i) begin
            addr_q  <= line_align(bus_io.address_i);
            read_q  <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          if (bus_io.resp_i) begin
            line_q[cnt] <= bus_io.burst_i;
            if (last_beat) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WR: begin
          if (bus_io.resp_i) begin
            if (last_beat) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              // Present the next beat so it is stable for the following strobe.
              burst_q <= wbuf_q[cnt + beat_idx_t'(1)];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.line_o    = line_q;
  assign bus_io.burst_o   = burst_q;
  assign bus_io.address_o = addr_q;
  assign bus_io.read_o    = read_q;
  assign bus_io.write_o   = write_q;
  assign bus_io.resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Bench for cacheline_burst_adapter: cache driver, memory model and scoreboard monitor.
module tb_cacheline_burst_adapter;
  import cache_types_pkg::*;

  typedef struct {
    logic       is_wr;
    cacheline_t line;
    addr_t      addr;
  } exp_t;

  logic clk;
  logic rst_n;
  cacheline_burst_adapter_if bus ();

  cacheline_burst_adapter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int unsigned checks;
  int unsigned errors;
  exp_t        sb_q[$];
  beat_t       wbeat_q[$];
  logic        gap_q[$];
  beat_t       rd_data[4];
  cacheline_t  last_line;
  logic        spur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory model: strobes while a burst is requested, following gap_q when loaded.
  initial begin
    int   idx;
    logic strobe;
    idx          = 0;
    bus.resp_i   = 1'b0;
    bus.burst_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.read_o || bus.write_o) begin
        strobe = (gap_q.size() > 0) ? gap_q.pop_front() : 1'b1;
      end else begin
        strobe = 1'b0;
        idx    = 0;
      end
      bus.resp_i  = strobe || spur;
      bus.burst_i = (strobe && bus.read_o && idx < 4) ? rd_data[idx] : 64'hDEAD_BEEF_0BAD_F00D;
      if (strobe) idx++;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.read_o || bus.write_o) begin
        if (sb_q.size() == 0) check_eq("active_no_req", 256'({bus.read_o, bus.write_o}), 256'(0));
        else                  check_eq("addr_o", 256'(bus.address_o), 256'(sb_q[0].addr));
      end
      if (bus.write_o && bus.resp_i) begin
        if (wbeat_q.size() == 0) check_eq("wr_beat_extra", 256'(bus.write_o), 256'(0));
        else                     check_eq("wr_beat", 256'(bus.burst_o), 256'(wbeat_q.pop_front()));
      end
      if (bus.resp_o) begin
        check_eq("resp_rw_low", 256'({bus.read_o, bus.write_o}), 256'(0));
        if (sb_q.size() == 0) begin
          check_eq("resp_unexpected", 256'(bus.resp_o), 256'(0));
        end else begin
          e = sb_q.pop_front();
          check_eq(e.is_wr ? "wr_line_keep" : "rd_line", bus.line_o, e.line);
        end
      end
    end
  end

  // One cache request (read, write or both); returns cycle of each resp_o and active cycles.
  task automatic xfer(input logic rd, input logic wr, input addr_t addr, input cacheline_t wline,
                      output int lat1, output int lat2, output int act);
    exp_t e;
    int   n;
    int   got;
    int   need;
    need = int'(rd) + int'(wr);
    if (wr) begin
      e.is_wr = 1'b1;
      e.line  = last_line;
      e.addr  = addr & 32'hFFFF_FFE0;
      sb_q.push_back(e);
      for (int b = 0; b < 4; b++) wbeat_q.push_back(wline[b*64 +: 64]);
    end
    if (rd) begin
      e.is_wr   = 1'b0;
      e.line    = {rd_data[3], rd_data[2], rd_data[1], rd_data[0]};
      e.addr    = addr & 32'hFFFF_FFE0;
      last_line = e.line;
      sb_q.push_back(e);
    end
    bus.address_i = addr;
    bus.line_i    = wline;
    bus.read_i    = rd;
    bus.write_i   = wr;
    n    = 1;
    got  = 0;
    lat1 = 0;
    lat2 = 0;
    act  = 0;
    while (got < need && n < 60) begin
      tick;
      n++;
      // Inputs are don't-care once captured; scramble them to prove it.
      if (!(rd && wr)) begin
        bus.address_i = ~addr;
        bus.line_i    = ~wline;
      end
      if (bus.read_o || bus.write_o) act++;
      if (bus.resp_o) begin
        got++;
        if (got == 1) lat1 = n;
        else          lat2 = n;
        tick;
        n++;
        if (bus.write_i) bus.write_i = 1'b0;
        else             bus.read_i  = 1'b0;
      end
    end
    if (got < need) check_eq("xfer_timeout", 256'(got), 256'(need));
  endtask

  initial begin
    int lat1, lat2, act;
    cacheline_t wline;
    checks        = 0;
    errors        = 0;
    spur          = 1'b0;
    last_line     = '0;
    rst_n         = 1'b0;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    #3;
    check_eq("rst_line", bus.line_o, 256'(0));
    check_eq("rst_outs", 256'({bus.burst_o, bus.address_o, bus.read_o, bus.write_o, bus.resp_o}),
             256'(0));
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    // Back-to-back read
    rd_data[0] = 64'h1111_1111_1111_1111;
    rd_data[1] = 64'h2222_2222_2222_2222;
    rd_data[2] = 64'h3333_3333_3333_3333;
    rd_data[3] = 64'h4444_4444_4444_4444;
    xfer(1'b1, 1'b0, 32'h0000_1234, '0, lat1, lat2, act);
    check_eq("rd_latency", 256'(lat1), 256'(6));
    check_eq("rd_read_o_cycles", 256'(act), 256'(4));
    check_eq("rd_addr_hold", 256'(bus.address_o), 256'(32'h0000_1220));
    check_eq("rd_line_hold", bus.line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Write: beats A..D, line_o untouched
    wline = {64'hD, 64'hC, 64'hB, 64'hA};
    xfer(1'b0, 1'b1, 32'h8000_003F, wline, lat1, lat2, act);
    check_eq("wr_latency", 256'(lat1), 256'(6));
    check_eq("wr_write_o_cycles", 256'(act), 256'(4));
    check_eq("wr_addr_hold", 256'(bus.address_o), 256'(32'h8000_0020));
    check_eq("wr_line_o_keep", bus.line_o, last_line);

    // Read with strobe gaps
    for (int b = 0; b < 4; b++) rd_data[b] = {$urandom, $urandom};
    gap_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    xfer(1'b1, 1'b0, 32'h0000_5A5C, '0, lat1, lat2, act);
    check_eq("gap_latency", 256'(lat1), 256'(9));
    check_eq("gap_read_o_cycles", 256'(act), 256'(7));

    // Read and write together: write first, then the read
    for (int b = 0; b < 4; b++) rd_data[b] = {$urandom, $urandom};
    wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xfer(1'b1, 1'b1, 32'h0012_3440, wline, lat1, lat2, act);
    check_eq("both_wr_latency", 256'(lat1), 256'(6));
    check_eq("both_rd_latency", 256'(lat2), 256'(12));
    check_eq("both_active_cycles", 256'(act), 256'(8));

    // Spurious resp_i in IDLE and DONE
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_eq("spur_idle_outs", 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'(0));
    end
    for (int b = 0; b < 4; b++) rd_data[b] = {$urandom, $urandom};
    xfer(1'b1, 1'b0, 32'h0000_0100, '0, lat1, lat2, act);
    check_eq("spur_rd_latency", 256'(lat1), 256'(6));
    for (int i = 0; i < 3; i++) begin
      tick;
      check_eq("spur_after_outs", 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'(0));
    end
    spur = 1'b0;
    tick;
    for (int b = 0; b < 4; b++) rd_data[b] = {$urandom, $urandom};
    xfer(1'b1, 1'b0, 32'h0000_0200, '0, lat1, lat2, act);
    check_eq("post_spur_latency", 256'(lat1), 256'(6));

    // Reset after two read beats aborts the burst
    for (int b = 0; b < 4; b++) rd_data[b] = {$urandom, $urandom};
    begin
      exp_t e;
      e.is_wr = 1'b0;
      e.line  = '0;
      e.addr  = 32'h0000_0300;
      sb_q.push_back(e);
    end
    bus.address_i = 32'h0000_0300;
    bus.read_i    = 1'b1;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check_eq("abort_line", bus.line_o, 256'(0));
    check_eq("abort_outs", 256'({bus.burst_o, bus.address_o, bus.read_o, bus.write_o, bus.resp_o}),
             256'(0));
    bus.read_i = 1'b0;
    sb_q.delete();
    wbeat_q.delete();
    last_line = '0;
    tick;
    rst_n = 1'b1;
    tick;
    for (int b = 0; b < 4; b++) rd_data[b] = {$urandom, $urandom};
    xfer(1'b1, 1'b0, 32'h0000_0300, '0, lat1, lat2, act);
    check_eq("reissue_latency", 256'(lat1), 256'(6));
    for (int i = 0; i < 4; i++) tick;
    check_eq("sb_drained", 256'(sb_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
